// File: rtl/pe_core_if.sv
// Port bundle for pe_core: sample, coefficient and program load,
// result output and the neighbour transfer lane.
interface pe_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32
);
    logic                    din_pe_v;
    logic [2*DATA_WIDTH-1:0] din_pe;
    logic                    din_tx_v;
    logic [2*DATA_WIDTH-1:0] din_tx;
    logic                    inst_in_v;
    logic [INST_WIDTH-1:0]   inst_in;
    logic                    alpha_v;
    logic                    dout_pe_v;
    logic [2*DATA_WIDTH-1:0] dout_pe;
    logic                    dout_tx_v;
    logic [2*DATA_WIDTH-1:0] dout_tx;

    modport master (
        output din_pe_v, din_pe,
        output din_tx_v, din_tx,
        output inst_in_v, inst_in,
        output alpha_v,
        input  dout_pe_v, dout_pe,
        input  dout_tx_v, dout_tx
    );

    modport slave (
        input  din_pe_v, din_pe,
        input  din_tx_v, din_tx,
        input  inst_in_v, inst_in,
        input  alpha_v,
        output dout_pe_v, dout_pe,
        output dout_tx_v, dout_tx
    );
endinterface

// File: rtl/pe_core.sv
// Complex-arithmetic processing element: loads a program and a sample
// burst, runs it through a 3-stage pipeline, and forwards a transfer lane.
module pe_core #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    pe_core_if.slave io
);

    localparam int CW = 2 * DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH + 2;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_MADD = 3'b101;
    localparam logic [2:0] OP_MSUB = 3'b110;
    localparam logic [CW-1:0] ONE =
        {{(DATA_WIDTH-1){1'b0}}, 1'b1, {DATA_WIDTH{1'b0}}};

    typedef struct packed {
        logic [2:0] op;
        logic       coef_en;
        logic [3:0] k;
        logic [7:0] src_b;
        logic [7:0] src_a;
        logic [7:0] dst;
    } inst_t;

    typedef struct packed {
        logic          valid;
        logic [2:0]    op;
        logic          coef_en;
        logic [3:0]    k;
        logic [7:0]    dst;
        logic [CW-1:0] a;
        logic [CW-1:0] b;
    } s1_t;

    typedef struct packed {
        logic          valid;
        logic [2:0]    op;
        logic [7:0]    dst;
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic [CW-1:0] m;
    } s2_t;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [3:0]      pc_q, pc_d;
    logic [4:0]      prog_cnt_q, prog_cnt_d;
    logic [7:0]      data_cnt_q, data_cnt_d;
    logic [4:0]      cptr_q, cptr_d;
    logic            inst_v_q, inst_v_d;
    logic            pe_v_q, pe_v_d;
    logic            alpha_q, alpha_d;
    logic            pe_alpha_q, pe_alpha_d;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic            dout_pe_v_q, dout_pe_v_d;
    logic [CW-1:0]   dout_pe_q, dout_pe_d;
    logic            tx_v_q, tx_v_d;
    logic [CW-1:0]   tx_q, tx_d;
    logic [CW-1:0]   coef_q [16];
    logic [CW-1:0]   coef_d [16];

    logic [INST_WIDTH-1:0] pmem_q [16];
    logic [CW-1:0]         dmem_q [256];

    logic          busy, trig;
    logic          inst_rise, inst_fall;
    logic          pe_rise, pe_fall, alpha_rise;
    logic          pm_we;
    logic [3:0]    pm_addr;
    logic          ld_we;
    logic [7:0]    ld_addr;
    logic          dm_we;
    logic [7:0]    dm_addr;
    logic [CW-1:0] dm_wdata;
    inst_t         iss;
    logic          is_mult, is_madd, is_msub;
    logic [CW-1:0] coef_sel;
    logic signed [PW-1:0] xr, xi, yr, yi, ar, ai, pr, pi;
    logic [DATA_WIDTH-1:0] rr, ri;
    logic [CW-1:0] res;

    always_comb begin
        busy = (state_q == ST_RUN) || s1_q.valid || s2_q.valid;
        inst_rise = io.inst_in_v && !inst_v_q;
        inst_fall = inst_v_q && !io.inst_in_v;
        pe_rise = io.din_pe_v && !pe_v_q;
        pe_fall = pe_v_q && !io.din_pe_v;
        alpha_rise = io.alpha_v && !alpha_q;
        // Both fall conditions in one cycle still start a single run.
        trig = !busy &&
               ((pe_fall && !pe_alpha_q && prog_cnt_q != 5'd0) ||
                (inst_fall && data_cnt_q != 8'd0));
    end

    always_comb begin
        inst_v_d = io.inst_in_v;
        pe_v_d = io.din_pe_v;
        alpha_d = io.alpha_v;
        pe_alpha_d = io.din_pe_v ? io.alpha_v : pe_alpha_q;
        prog_cnt_d = prog_cnt_q;
        pm_we = 1'b0;
        pm_addr = prog_cnt_q[3:0];
        if (io.inst_in_v && !busy) begin
            if (inst_rise) prog_cnt_d = 5'd0;
            if (prog_cnt_d < 5'd16) begin
                pm_we = 1'b1;
                pm_addr = prog_cnt_d[3:0];
                prog_cnt_d = prog_cnt_d + 5'd1;
            end
        end
    end

    always_comb begin
        data_cnt_d = data_cnt_q;
        cptr_d = alpha_rise ? 5'd0 : cptr_q;
        coef_d = coef_q;
        ld_we = 1'b0;
        ld_addr = data_cnt_q;
        if (io.din_pe_v && !busy) begin
            if (io.alpha_v) begin
                if (cptr_d < 5'd16) begin
                    coef_d[cptr_d[3:0]] = io.din_pe;
                    cptr_d = cptr_d + 5'd1;
                end
            end else begin
                if (pe_rise) data_cnt_d = 8'd0;
                if (data_cnt_d < 8'd128) begin
                    ld_we = 1'b1;
                    ld_addr = data_cnt_d;
                    data_cnt_d = data_cnt_d + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_RUN;
                    pc_d = 4'd0;
                end
            end
            ST_RUN: begin
                pc_d = pc_q + 4'd1;
                if ({1'b0, pc_q} == prog_cnt_q - 5'd1) state_d = ST_IDLE;
            end
        endcase
    end

    // Operands are read at issue, so the two following instructions
    // still see a destination's old contents.
    always_comb begin
        iss = pmem_q[pc_q];
        s1_d = '0;
        s1_d.valid = (state_q == ST_RUN);
        s1_d.op = iss.op;
        s1_d.coef_en = iss.coef_en;
        s1_d.k = iss.k;
        s1_d.dst = iss.dst;
        s1_d.a = dmem_q[iss.src_a];
        s1_d.b = dmem_q[iss.src_b];
    end

    always_comb begin
        is_mult = (s1_q.op == OP_MULT);
        is_madd = (s1_q.op == OP_MADD);
        is_msub = (s1_q.op == OP_MSUB);
        coef_sel = s1_q.coef_en ? coef_q[s1_q.k] : ONE;
        s2_d = '0;
        s2_d.valid = s1_q.valid && (is_mult || is_madd || is_msub);
        s2_d.op = s1_q.op;
        s2_d.dst = s1_q.dst;
        s2_d.a = s1_q.a;
        s2_d.b = s1_q.b;
        s2_d.m = is_mult ? s1_q.a : coef_sel;
    end

    always_comb begin
        xr = PW'($signed(s2_q.m[CW-1:DATA_WIDTH]));
        xi = PW'($signed(s2_q.m[DATA_WIDTH-1:0]));
        yr = PW'($signed(s2_q.b[CW-1:DATA_WIDTH]));
        yi = PW'($signed(s2_q.b[DATA_WIDTH-1:0]));
        ar = PW'($signed(s2_q.a[CW-1:DATA_WIDTH]));
        ai = PW'($signed(s2_q.a[DATA_WIDTH-1:0]));
        pr = xr * yr - xi * yi;
        pi = xr * yi + xi * yr;
        unique case (1'b1)
            (s2_q.op == OP_MULT): begin
                rr = DATA_WIDTH'(pr);
                ri = DATA_WIDTH'(pi);
            end
            (s2_q.op == OP_MSUB): begin
                rr = DATA_WIDTH'(ar - pr);
                ri = DATA_WIDTH'(ai - pi);
            end
            default: begin
                rr = DATA_WIDTH'(ar + pr);
                ri = DATA_WIDTH'(ai + pi);
            end
        endcase
        res = {rr, ri};
        dout_pe_v_d = s2_q.valid;
        dout_pe_d = s2_q.valid ? res : dout_pe_q;
        dm_we = s2_q.valid || ld_we;
        dm_addr = s2_q.valid ? s2_q.dst : ld_addr;
        dm_wdata = s2_q.valid ? res : io.din_pe;
        tx_v_d = io.din_tx_v;
        tx_d = io.din_tx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q <= '0;
            prog_cnt_q <= '0;
            data_cnt_q <= '0;
            cptr_q <= '0;
            inst_v_q <= 1'b0;
            pe_v_q <= 1'b0;
            alpha_q <= 1'b0;
            pe_alpha_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            dout_pe_v_q <= 1'b0;
            dout_pe_q <= '0;
            tx_v_q <= 1'b0;
            tx_q <= '0;
            for (int i = 0; i < 16; i++) coef_q[i] <= ONE;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            prog_cnt_q <= prog_cnt_d;
            data_cnt_q <= data_cnt_d;
            cptr_q <= cptr_d;
            inst_v_q <= inst_v_d;
            pe_v_q <= pe_v_d;
            alpha_q <= alpha_d;
            pe_alpha_q <= pe_alpha_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            dout_pe_v_q <= dout_pe_v_d;
            dout_pe_q <= dout_pe_d;
            tx_v_q <= tx_v_d;
            tx_q <= tx_d;
            coef_q <= coef_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pm_we) pmem_q[pm_addr] <= io.inst_in;
        if (dm_we) dmem_q[dm_addr] <= dm_wdata;
    end

    assign io.dout_pe_v = dout_pe_v_q;
    assign io.dout_pe = dout_pe_q;
    assign io.dout_tx_v = tx_v_q;
    assign io.dout_tx = tx_q;

endmodule

// File: tb/tb_pe_core.sv
// Directed bench for pe_core: load/run sequences with
// hand-computed complex results, hazards, abort and overflow.
module tb_pe_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   fall_cyc = 0;

    logic [31:0] words[$];
    logic [31:0] exp_val[$];
    logic [31:0] got_val[$];
    int          got_cyc[$];

    pe_core_if #(.DATA_WIDTH(16), .INST_WIDTH(32)) bus ();

    pe_core dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dout_pe_v) begin
            got_val.push_back(bus.dout_pe);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // kind: 0 program, 1 samples, 2 coefficients
    task automatic send(input int kind);
        foreach (words[i]) begin
            if (kind == 0) begin
                bus.inst_in_v = 1'b1;
                bus.inst_in = words[i];
            end else begin
                bus.din_pe_v = 1'b1;
                bus.alpha_v = (kind == 2);
                bus.din_pe = words[i];
            end
            tick();
        end
        bus.inst_in_v = 1'b0;
        bus.din_pe_v = 1'b0;
        bus.alpha_v = 1'b0;
        fall_cyc = cyc + 1;
        words.delete();
        tick();
    endtask

    task automatic check_run(input string tag);
        check($sformatf("%s_n", tag), got_val.size(), exp_val.size());
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            check($sformatf("%s_v%0d", tag, i), got_val[i], exp_val[i]);
            check($sformatf("%s_lat%0d", tag, i),
                  got_cyc[i] - fall_cyc, 3 + i);
        end
        got_val.delete();
        got_cyc.delete();
        exp_val.delete();
    endtask

    initial begin
        int n;
        bus.din_pe_v = 1'b0;
        bus.din_pe = '0;
        bus.din_tx_v = 1'b0;
        bus.din_tx = '0;
        bus.inst_in_v = 1'b0;
        bus.inst_in = '0;
        bus.alpha_v = 1'b0;
        idle(3);
        rst = 1'b1;
        tick();
        check("rst_pe_v", bus.dout_pe_v, 0);
        check("rst_pe", bus.dout_pe, 0);
        check("rst_tx_v", bus.dout_tx_v, 0);
        check("rst_tx", bus.dout_tx, 0);

        bus.din_tx = 32'h1234_5678;
        bus.din_tx_v = 1'b1;
        tick();
        check("tx_data", bus.dout_tx, 32'h1234_5678);
        check("tx_v", bus.dout_tx_v, 1);
        bus.din_tx = 32'hDEAD_BEEF;
        bus.din_tx_v = 1'b0;
        tick();
        check("tx_data2", bus.dout_tx, 32'hDEAD_BEEF);
        check("tx_v2", bus.dout_tx_v, 0);

        words.push_back(32'h8001_0080);
        words.push_back(32'h8003_0281);
        words.push_back(32'h8005_0482);
        send(0);
        idle(8);
        check("nodata_pulses", got_val.size(), 0);

        words.push_back(32'h0004_0002);
        words.push_back(32'h0003_0001);
        words.push_back(32'h0008_0006);
        words.push_back(32'h0007_0005);
        words.push_back(32'h000C_000A);
        words.push_back(32'h000B_0009);
        send(1);
        idle(7);
        exp_val.push_back(32'h000A_000A);
        exp_val.push_back(32'h001A_0052);
        exp_val.push_back(32'h002A_00DA);
        check_run("mult3");
        check("mem80", dut.dmem_q[8'h80], 32'h000A_000A);
        check("mem81", dut.dmem_q[8'h81], 32'h001A_0052);
        check("mem82", dut.dmem_q[8'h82], 32'h002A_00DA);
        check("hold_v", bus.dout_pe_v, 0);
        check("hold_pe", bus.dout_pe, 32'h002A_00DA);

        words.push_back(32'hB101_0000);
        words.push_back(32'hD203_0200);
        send(0);
        idle(6);
        exp_val.push_back(32'h0007_0003);
        exp_val.push_back(32'h0001_0001);
        check_run("rerun");

        words.push_back(32'h0001_0000);
        words.push_back(32'h0000_0001);
        send(2);
        idle(6);
        check("coef_pulses", got_val.size(), 0);

        words.push_back(32'hB101_0000);
        words.push_back(32'h0000_0000);
        send(0);
        idle(6);
        exp_val.push_back(32'h0000_0004);
        check_run("coef_old");
        check("nop_nowb", dut.dmem_q[8'h00], 32'h0000_0004);

        words.push_back(32'h0004_0002);
        words.push_back(32'h0003_0001);
        send(1);
        idle(6);
        exp_val.push_back(32'h0003_0005);
        check_run("coef_j");

        words.push_back(32'h8001_0080);
        send(0);
        idle(6);
        exp_val.push_back(32'h0004_0012);
        check_run("mult_new");

        words.push_back(32'h7FFF_0000);
        words.push_back(32'h0002_0000);
        send(1);
        idle(6);
        exp_val.push_back(32'hFFFE_0000);
        check_run("wrap");

        words.push_back(32'h8001_0005);
        words.push_back(32'hA005_0506);
        words.push_back(32'hA005_0506);
        words.push_back(32'hA005_0506);
        send(0);
        idle(8);
        exp_val.push_back(32'hFFFE_0000);
        exp_val.push_back(32'h0016_0012);
        exp_val.push_back(32'h0016_0012);
        exp_val.push_back(32'hFFFC_0000);
        check_run("hazard");

        for (int i = 0; i < 8; i++) words.push_back(32'h8001_0080 + i);
        send(0);
        n = 0;
        while (got_val.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        check("abort_started", got_val.size(), 1);
        rst = 1'b0;
        #1;
        check("abort_pe_v", bus.dout_pe_v, 0);
        check("abort_pe", bus.dout_pe, 0);
        got_val.delete();
        got_cyc.delete();
        idle(3);
        rst = 1'b1;
        idle(12);
        check("abort_quiet", got_val.size(), 0);

        for (int i = 0; i < 16; i++) words.push_back(32'h8001_0080 + i);
        words.push_back(32'h8000_0090);
        send(0);
        idle(6);
        check("ovf_nodata", got_val.size(), 0);
        words.push_back(32'h0001_0001);
        words.push_back(32'h0002_0000);
        send(1);
        idle(22);
        for (int i = 0; i < 16; i++) exp_val.push_back(32'h0002_0002);
        check_run("ovf16");
        check("mem8f", dut.dmem_q[8'h8F], 32'h0002_0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
